plot_rect_fill: RTL and testbench
=================================

# plot_rect_fill

Parametrised rectangle-fill plotter: on a `start` pulse it latches an origin, a size and a colour, then emits one pixel coordinate per cycle in row-major order until the rectangle is covered. It generalises the full-screen black clear to any rectangle, any colour and any screen size. The rectangle is clipped to the screen, and a `hold` back-pressure input lets it share the VGA adapter write port. It sits between the game/draw control FSM and the VGA adapter (`x`, `y`, `colour`, `plot`).

## Interface
- `X_W`, default 9: x coordinate width.
- `Y_W`, default 8: y coordinate width.
- `COLOUR_W`, default 3: colour width.
- `SCREEN_W`, default 320: visible columns; x ≥ `SCREEN_W` is clipped.
- `SCREEN_H`, default 240: visible rows; y ≥ `SCREEN_H` is clipped.

Ports:
- `clk`, in, 1: single clock; all state changes on the rising edge.
- `resetn`, in, 1: reset, asynchronous and active-low.
- `start`, in, 1: request; sampled only in IDLE.
- `x0`, in, `X_W`: left column.
- `y0`, in, `Y_W`: top row.
- `w`, in, `X_W`: width in pixels.
- `h`, in, `Y_W`: height in pixels.
- `colour_in`, in, `COLOUR_W`: fill colour.
- `hold`, in, 1: stall; while high no pixel is emitted and no counter advances.
- `x_coord`, out, `X_W`: pixel column.
- `y_coord`, out, `Y_W`: pixel row.
- `colour`, out, `COLOUR_W`: latched fill colour.
- `plot`, out, 1: a pixel write is valid this cycle.
- `busy`, out, 1: high in LOAD and DRAW.
- `done`, out, 1: one-cycle completion pulse.

## Operation
- FSM states: IDLE, LOAD, DRAW, DONE (registered).
- IDLE
  - `start`=1 latches `x0`, `y0`, `w`, `h` and `colour_in` into internal registers, then goes to LOAD.
  - `start`=0 stays in IDLE.
- LOAD (exactly 1 cycle)
  - Goes to DONE with no pixels if `w`=0, `h`=0, `x0`≥`SCREEN_W` or `y0`≥`SCREEN_H`.
  - Otherwise computes `xe` = min(`x0`+`w`−1, `SCREEN_W`−1) and `ye` = min(`y0`+`h`−1, `SCREEN_H`−1) in `X_W`+1 / `Y_W`+1 bits, so the sums never wrap.
  - Sets `cx`←`x0`, `cy`←`y0`, then goes to DRAW.
- DRAW, with `hold`=0
  - `plot`=1 and the pixel is (`cx`, `cy`).
  - If `cx`≠`xe`: `cx`++.
  - Else `cx`←`x0`; then if `cy`=`ye` go to DONE, else `cy`++.
- DRAW, with `hold`=1: `plot`=0; `cx`, `cy` and the state are frozen.
- DONE: `done`=1 for one cycle, then IDLE.
- Pixels emitted = (`xe`−`x0`+1)·(`ye`−`y0`+1), each exactly once, left-to-right then top-to-bottom.
- `start` is ignored in LOAD, DRAW and DONE; no queueing.
- Input changes after the latch cycle have no effect on the current fill.
- `x_coord` = `cx`, `y_coord` = `cy`, `colour` = latched colour, all straight from registers.
- `plot` = (state==DRAW) & !`hold` is combinational; `hold` → `plot` has zero latency.

## Timing
- Reset values, applied asynchronously when `resetn`=0: state IDLE, `cx`=0, `cy`=0, `colour`=0, `plot`=0, `busy`=0, `done`=0.
- Reset mid-fill aborts immediately. No `done` is produced, and the block restarts in IDLE on the first edge after release.
- Latency, with `start` sampled at edge E0:
  - LOAD occupies E0→E1.
  - The first `plot` is high in the cycle after E1.
  - With no `hold`, the last pixel is at E1+N−1.
  - `done` is high in the following cycle, and IDLE follows one cycle later.
  - Total E0 to `done` = N+2 cycles.
- Empty or fully off-screen request: `done` is high 2 cycles after E0 and `plot` never asserts.
- `hold` asserted on the final pixel delays DONE until a cycle with `hold`=0.
- A `start` held high through DONE starts a new fill only once back in IDLE, i.e. in the cycle after `done`.

## Test plan
- Reset during idle and mid-fill:
  - Assert `resetn`=0 at an arbitrary point, not on an edge → `plot`, `busy`, `done`, `x_coord`, `y_coord` and `colour` go to 0 immediately.
  - Start a 4×4 fill and apply reset after 5 pixels → no `done` pulse; a later `start` begins again from its own origin.
- Basic 3×2 fill: `x0`=10, `y0`=20, colour 5 → 6 plots in order (10,20) (11,20) (12,20) (10,21) (11,21) (12,21), `colour`=5 throughout, `done` pulse 8 cycles after `start`.
- Right and bottom clipping: `x0`=318, `w`=5, `y0`=239, `h`=3 → exactly 2 plots, (318,239) and (319,239), then `done`.
- Degenerate and off-screen requests:
  - `w`=0 → `done` 2 cycles after `start`, zero plots.
  - `x0`=320, `w`=4 → same result.
- Back-pressure: 2×2 fill with `hold` high on cycles 2–4 of DRAW and again on the final pixel → still exactly 4 distinct plots, `plot`=0 on every held cycle, `done` only after the last unheld pixel.
- Full-screen clear equivalent: `x0`=0, `y0`=0, `w`=320, `h`=240 → 76800 plots, last pixel (319,239), `done` at start+76802 cycles. A `start` pulse issued mid-fill is ignored.

Source files
------------

// File: rtl/plot_rect_fill_if.sv
// plot_rect_fill_if: request, back-pressure and pixel-write bus of the
// rectangle-fill plotter (master = control side, slave = plotter).
interface plot_rect_fill_if #(
    parameter int X_W      = 9,
    parameter int Y_W      = 8,
    parameter int COLOUR_W = 3
);
    logic                start;
    logic [X_W-1:0]      x0;
    logic [Y_W-1:0]      y0;
    logic [X_W-1:0]      w;
    logic [Y_W-1:0]      h;
    logic [COLOUR_W-1:0] colour_in;
    logic                hold;
    logic [X_W-1:0]      x_coord;
    logic [Y_W-1:0]      y_coord;
    logic [COLOUR_W-1:0] colour;
    logic                plot;
    logic                busy;
    logic                done;

    modport master (
        output start, x0, y0, w, h, colour_in, hold,
        input  x_coord, y_coord, colour, plot, busy, done
    );

    modport slave (
        input  start, x0, y0, w, h, colour_in, hold,
        output x_coord, y_coord, colour, plot, busy, done
    );
endinterface

// File: rtl/plot_rect_fill.sv
// plot_rect_fill: clipped rectangle fill, one pixel per cycle in
// row-major order, stallable by hold for a shared VGA write port.
module plot_rect_fill #(
    parameter int X_W      = 9,
    parameter int Y_W      = 8,
    parameter int COLOUR_W = 3,
    parameter int SCREEN_W = 320,
    parameter int SCREEN_H = 240
) (
    input logic             clk,
    input logic             resetn,
    plot_rect_fill_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DRAW,
        DONE
    } state_t;

    localparam logic [X_W:0] X_LAST = (X_W+1)'(SCREEN_W - 1);
    localparam logic [Y_W:0] Y_LAST = (Y_W+1)'(SCREEN_H - 1);

    state_t              state_q, state_d;
    logic [X_W-1:0]      x0_q, x0_d;
    logic [Y_W-1:0]      y0_q, y0_d;
    logic [X_W-1:0]      w_q, w_d;
    logic [Y_W-1:0]      h_q, h_d;
    logic [COLOUR_W-1:0] colour_q, colour_d;
    logic [X_W-1:0]      xe_q, xe_d;
    logic [Y_W-1:0]      ye_q, ye_d;
    logic [X_W-1:0]      cx_q, cx_d;
    logic [Y_W-1:0]      cy_q, cy_d;

    // One extra bit so x0+w-1 / y0+h-1 cannot wrap before clipping.
    logic [X_W:0]        x_sum;
    logic [Y_W:0]        y_sum;
    logic                empty;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= IDLE;
            x0_q     <= '0;
            y0_q     <= '0;
            w_q      <= '0;
            h_q      <= '0;
            colour_q <= '0;
            xe_q     <= '0;
            ye_q     <= '0;
            cx_q     <= '0;
            cy_q     <= '0;
        end else begin
            state_q  <= state_d;
            x0_q     <= x0_d;
            y0_q     <= y0_d;
            w_q      <= w_d;
            h_q      <= h_d;
            colour_q <= colour_d;
            xe_q     <= xe_d;
            ye_q     <= ye_d;
            cx_q     <= cx_d;
            cy_q     <= cy_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        x0_d     = x0_q;
        y0_d     = y0_q;
        w_d      = w_q;
        h_d      = h_q;
        colour_d = colour_q;
        xe_d     = xe_q;
        ye_d     = ye_q;
        cx_d     = cx_q;
        cy_d     = cy_q;

        x_sum = {1'b0, x0_q} + {1'b0, w_q} - (X_W+1)'(1);
        y_sum = {1'b0, y0_q} + {1'b0, h_q} - (Y_W+1)'(1);
        empty = (w_q == '0) || (h_q == '0) ||
                ({1'b0, x0_q} > X_LAST) ||
                ({1'b0, y0_q} > Y_LAST);

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    x0_d     = bus.x0;
                    y0_d     = bus.y0;
                    w_d      = bus.w;
                    h_d      = bus.h;
                    colour_d = bus.colour_in;
                    state_d  = LOAD;
                end
            end
            LOAD: begin
                if (empty) begin
                    state_d = DONE;
                end else begin
                    xe_d    = (x_sum > X_LAST) ? X_LAST[X_W-1:0]
                                               : x_sum[X_W-1:0];
                    ye_d    = (y_sum > Y_LAST) ? Y_LAST[Y_W-1:0]
                                               : y_sum[Y_W-1:0];
                    cx_d    = x0_q;
                    cy_d    = y0_q;
                    state_d = DRAW;
                end
            end
            DRAW: begin
                if (!bus.hold) begin
                    if (cx_q != xe_q) begin
                        cx_d = cx_q + X_W'(1);
                    end else begin
                        cx_d = x0_q;
                        if (cy_q == ye_q) begin
                            state_d = DONE;
                        end else begin
                            cy_d = cy_q + Y_W'(1);
                        end
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.x_coord = cx_q;
    assign bus.y_coord = cy_q;
    assign bus.colour  = colour_q;
    assign bus.plot    = (state_q == DRAW) && !bus.hold;
    assign bus.busy    = (state_q == LOAD) || (state_q == DRAW);
    assign bus.done    = (state_q == DONE);
endmodule

// File: tb/tb_plot_rect_fill.sv
// tb_plot_rect_fill: table vectors, hand sequences and randomised fills
// checked against a pixel-list model of the clipped rectangle.
module tb_plot_rect_fill;
    localparam int X_W = 9;
    localparam int Y_W = 8;
    localparam int C_W = 3;
    localparam int SW  = 320;
    localparam int SH  = 240;

    logic clk    = 1'b0;
    logic resetn = 1'b0;
    int   total  = 0;
    int   passed = 0;
    int   got_x[$];
    int   got_y[$];

    plot_rect_fill_if #(.X_W(X_W), .Y_W(Y_W), .COLOUR_W(C_W)) bus();

    plot_rect_fill #(
        .X_W(X_W), .Y_W(Y_W), .COLOUR_W(C_W),
        .SCREEN_W(SW), .SCREEN_H(SH)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int x0;
        int y0;
        int w;
        int h;
        int col;
        int n;
        int lx;
        int ly;
        bit mid;
    } vec_t;

    task automatic check(input string nm, input longint act,
                         input longint exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    endtask

    function automatic int outs();
        return int'({bus.x_coord, bus.y_coord, bus.colour,
                     bus.plot, bus.busy, bus.done});
    endfunction

    // hmode: 0 no hold, 1 random hold, 2 scripted hold pattern
    task automatic run_fill(input int ax0, input int ay0, input int aw,
                            input int ah, input int acol,
                            input int hmode, input bit mid,
                            input string nm);
        int ex[$];
        int ey[$];
        int n, k, rem, held, done_k, fh, mm;
        int bad_gate, bad_busy, bad_col;
        bit in_draw;
        for (int yy = ay0; yy < ay0 + ah; yy++)
            for (int xx = ax0; xx < ax0 + aw; xx++)
                if (xx < SW && yy < SH) begin
                    ex.push_back(xx);
                    ey.push_back(yy);
                end
        n = ex.size();
        got_x.delete();
        got_y.delete();
        rem = n; held = 0; done_k = -1; fh = 0;
        bad_gate = 0; bad_busy = 0; bad_col = 0; k = 0;

        @(posedge clk); #1;
        bus.x0        = X_W'(ax0);
        bus.y0        = Y_W'(ay0);
        bus.w         = X_W'(aw);
        bus.h         = Y_W'(ah);
        bus.colour_in = C_W'(acol);
        bus.hold      = 1'b0;
        bus.start     = 1'b1;

        while (k <= n + held + 20) begin
            @(posedge clk); #1;
            k++;
            if (k == 1) begin
                bus.start     = 1'b0;
                bus.x0        = X_W'($urandom);
                bus.y0        = Y_W'($urandom);
                bus.w         = X_W'($urandom);
                bus.h         = Y_W'($urandom);
                bus.colour_in = C_W'($urandom);
            end
            if (mid && k == 50) begin
                bus.x0    = X_W'(1);
                bus.y0    = Y_W'(1);
                bus.w     = X_W'(1);
                bus.h     = Y_W'(1);
                bus.start = 1'b1;
            end
            if (mid && k == 51) bus.start = 1'b0;
            in_draw = (k >= 2) && (rem > 0);
            case (hmode)
                1: bus.hold = ($urandom_range(0, 3) == 0);
                2: bus.hold = in_draw &&
                              ((k - 2 >= 1 && k - 2 <= 3) ||
                               (rem == 1 && fh < 2));
                default: bus.hold = 1'b0;
            endcase
            if (hmode == 2 && bus.hold && rem == 1) fh++;
            #1;
            if (bus.plot !== (in_draw && !bus.hold)) bad_gate++;
            if (bus.busy !== ((k == 1) || in_draw)) bad_busy++;
            if (bus.plot === 1'b1) begin
                got_x.push_back(int'(bus.x_coord));
                got_y.push_back(int'(bus.y_coord));
                if (int'(bus.colour) != acol) bad_col++;
            end
            if (in_draw) begin
                if (bus.hold) held++;
                else rem--;
            end
            if (bus.done === 1'b1) begin
                done_k = k;
                break;
            end
        end
        bus.hold  = 1'b0;
        bus.start = 1'b0;

        mm = -1;
        for (int i = 0; i < n && i < got_x.size(); i++)
            if (got_x[i] != ex[i] || got_y[i] != ey[i]) begin
                mm = i;
                break;
            end
        check({nm, " done cycle"}, done_k, n + 2 + held);
        check({nm, " pixel count"}, got_x.size(), n);
        check({nm, " first out-of-order pixel"}, mm, -1);
        check({nm, " plot gating errors"}, bad_gate, 0);
        check({nm, " busy errors"}, bad_busy, 0);
        check({nm, " colour errors"}, bad_col, 0);
        @(posedge clk); #2;
        check({nm, " busy/done after done"},
              int'({bus.busy, bus.done}), 0);
    endtask

    vec_t vecs[$];
    int   seen, dn;
    logic [1:0] seq_exp [4];

    initial begin
        bus.start = 1'b0; bus.hold = 1'b0;
        bus.x0 = '0; bus.y0 = '0; bus.w = '0; bus.h = '0;
        bus.colour_in = '0;

        #2;
        check("reset state outputs", outs(), 0);
        #20 resetn = 1'b1;

        vecs.push_back('{10, 20, 3, 2, 5, 6, 12, 21, 1'b0});
        vecs.push_back('{318, 239, 5, 3, 4, 2, 319, 239, 1'b0});
        vecs.push_back('{40, 40, 0, 5, 1, 0, 0, 0, 1'b0});
        vecs.push_back('{320, 10, 4, 2, 2, 0, 0, 0, 1'b0});
        vecs.push_back('{5, 5, 3, 0, 3, 0, 0, 0, 1'b0});
        vecs.push_back('{5, 240, 3, 3, 6, 0, 0, 0, 1'b0});
        vecs.push_back('{0, 0, 1, 1, 7, 1, 0, 0, 1'b0});
        vecs.push_back('{300, 5, 30, 1, 2, 20, 319, 5, 1'b0});
        vecs.push_back('{0, 0, 320, 240, 7, 76800, 319, 239, 1'b1});

        foreach (vecs[i]) begin
            string nm;
            nm = $sformatf("vec%0d", i);
            run_fill(vecs[i].x0, vecs[i].y0, vecs[i].w, vecs[i].h,
                     vecs[i].col, 0, vecs[i].mid, nm);
            check({nm, " table count"}, got_x.size(), vecs[i].n);
            if (vecs[i].n > 0 && got_x.size() > 0)
                check({nm, " last pixel"},
                      got_x[$] * 1000 + got_y[$],
                      vecs[i].lx * 1000 + vecs[i].ly);
        end

        // asynchronous reset while idle, away from a clock edge
        @(posedge clk); #3;
        resetn = 1'b0;
        #1 check("reset idle outputs", outs(), 0);
        #10 resetn = 1'b1;

        // reset after five pixels of a 4x4 fill
        @(posedge clk); #1;
        bus.x0 = 9'd50; bus.y0 = 8'd60; bus.w = 9'd4; bus.h = 8'd4;
        bus.colour_in = 3'd6; bus.start = 1'b1;
        seen = 0; dn = 0;
        for (int k = 1; k <= 20 && seen < 5; k++) begin
            @(posedge clk); #1;
            bus.start = 1'b0;
            #1;
            if (bus.plot === 1'b1) seen++;
            if (bus.done === 1'b1) dn++;
        end
        check("mid-fill 5th pixel",
              int'(bus.x_coord) * 1000 + int'(bus.y_coord), 50061);
        #1 resetn = 1'b0;
        #1 check("reset mid-fill outputs", outs(), 0);
        #10 resetn = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #2;
            if (bus.done === 1'b1) dn++;
        end
        check("no done after abort", dn, 0);
        run_fill(7, 9, 2, 1, 3, 0, 1'b0, "restart");

        run_fill(100, 100, 2, 2, 3, 2, 1'b0, "backpressure");

        // start held high through DONE: next fill only from IDLE
        seq_exp[0] = 2'b10;
        seq_exp[1] = 2'b01;
        seq_exp[2] = 2'b00;
        seq_exp[3] = 2'b10;
        @(posedge clk); #1;
        bus.x0 = 9'd5; bus.y0 = 8'd5; bus.w = 9'd0; bus.h = 8'd1;
        bus.colour_in = 3'd2; bus.start = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #2;
            check($sformatf("held start busy/done c%0d", k + 1),
                  int'({bus.busy, bus.done}), int'(seq_exp[k]));
        end
        bus.start = 1'b0;
        repeat (3) @(posedge clk);

        for (int r = 0; r < 12; r++)
            run_fill($urandom_range(0, 330), $urandom_range(0, 250),
                     $urandom_range(0, 24), $urandom_range(0, 12),
                     $urandom_range(0, 7), 1, 1'b0,
                     $sformatf("rand%0d", r));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
